// File: rtl/dep_tracker.sv
// -----------------------------------------------------------------------------
// dep_tracker
//
// Dependency tracker for the issue buffer. Each accepted instruction is placed
// in the lowest free slot. Its source and destination registers are recorded
// in per-register slot tables. A dependency vector is computed against the
// instructions still in flight. A per-slot dependency matrix keeps the
// outstanding producers of every entry. When a producer completes, its column
// is cleared so that its dependents become ready.
//
// Parameters
//   REGNUM   architectural register count (RW = $clog2(REGNUM))
//   BS       buffer slots (SW = $clog2(BS))
//   NSRC     source operands per instruction (1..3)
//   DEP_MODE 0 = RAW only, 1 = RAW + WAR + WAW
//   ZERO_REG 1 = register 0 never creates or carries a dependency
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   alloc_valid   new instruction offered this cycle
//   alloc_ready   a free slot exists
//   alloc_slot    slot the offered instruction would occupy
//   alloc_rs      source registers, operand k at [k*RW +: RW]
//   alloc_rs_en   per-operand used flags
//   alloc_rd      destination register
//   alloc_rd_en   destination used
//   cmpl_valid    completion strobe
//   cmpl_idx      completing slot
//   idt           dependency vector of the last accepted instruction
//   idt_valid     one-cycle pulse when idt was updated
//   ready_vec     valid slots with no outstanding dependency
//   count         number of occupied slots
// -----------------------------------------------------------------------------
module dep_tracker #(
    parameter int  REGNUM   = 32,
    parameter int  BS       = 16,
    parameter int  NSRC     = 2,
    parameter int  DEP_MODE = 1,
    parameter int  ZERO_REG = 1,
    localparam int RW       = $clog2(REGNUM),
    localparam int SW       = $clog2(BS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_valid,
    output logic               alloc_ready,
    output logic [SW-1:0]      alloc_slot,
    input  logic [NSRC*RW-1:0] alloc_rs,
    input  logic [NSRC-1:0]    alloc_rs_en,
    input  logic [RW-1:0]      alloc_rd,
    input  logic               alloc_rd_en,
    input  logic               cmpl_valid,
    input  logic [SW-1:0]      cmpl_idx,
    output logic [BS-1:0]      idt,
    output logic               idt_valid,
    output logic [BS-1:0]      ready_vec,
    output logic [SW:0]        count
);

    localparam int CW = SW + 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [BS-1:0] valid_q,     valid_d;
    logic [BS-1:0] rs_tbl_q [REGNUM];   // rs_tbl_q[r][s]: slot s reads r
    logic [BS-1:0] rs_tbl_d [REGNUM];
    logic [BS-1:0] rd_tbl_q [REGNUM];   // rd_tbl_q[r][s]: slot s writes r
    logic [BS-1:0] rd_tbl_d [REGNUM];
    logic [BS-1:0] dep_q    [BS];       // dep_q[i][j]: slot i waits on slot j
    logic [BS-1:0] dep_d    [BS];
    logic [BS-1:0] idt_q,       idt_d;
    logic          idt_valid_q, idt_valid_d;
    logic [SW:0]   count_q,     count_d;

    // -------------------------------------------------------------------------
    // Operand decode: register 0 optionally behaves as an unused operand
    // -------------------------------------------------------------------------
    logic [RW-1:0]   src_reg [NSRC];
    logic [NSRC-1:0] src_en;
    logic            dst_en;

    always_comb begin
        for (int k = 0; k < NSRC; k++) begin
            src_reg[k] = alloc_rs[k*RW +: RW];
            src_en[k]  = alloc_rs_en[k] & ~((ZERO_REG != 0) && (src_reg[k] == '0));
        end
        dst_en = alloc_rd_en & ~((ZERO_REG != 0) && (alloc_rd == '0));
    end

    // One flag per register: does the offered instruction read it?
    logic [REGNUM-1:0] src_hit;

    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        src_hit = '0;
        for (int r = 0; r < REGNUM; r++) begin
            for (int k = 0; k < NSRC; k++) begin
                if (src_en[k] && (src_reg[k] == RW'(r))) begin
                    src_hit[r] = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Free-slot search: lowest index with valid = 0
    // -------------------------------------------------------------------------
    logic [SW-1:0] free_slot;

    always_comb begin
        free_slot = '0;
        for (int i = BS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_slot = SW'(i);
            end
        end
    end

    assign alloc_ready = ~&valid_q;
    assign alloc_slot  = free_slot;

    logic accept;
    logic cmpl_act;

    assign accept   = alloc_valid & alloc_ready;
    // Completing an empty slot has no effect at all.
    assign cmpl_act = cmpl_valid & valid_q[cmpl_idx];

    // -------------------------------------------------------------------------
    // Dependency vector of the offered instruction
    // -------------------------------------------------------------------------
    logic [BS-1:0] cmpl_mask;
    logic [BS-1:0] live;
    logic [BS-1:0] raw_vec;
    logic [BS-1:0] war_vec;
    logic [BS-1:0] waw_vec;
    logic [BS-1:0] dep_vec;

    always_comb begin
        // A producer completing on this same edge is excluded, so the new
        // entry never waits on a slot that is being freed right now.
        cmpl_mask = '0;
        if (cmpl_valid) begin
            cmpl_mask[cmpl_idx] = 1'b1;
        end
        live = valid_q & ~cmpl_mask;

        raw_vec = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (src_en[k]) begin
                raw_vec = raw_vec | rd_tbl_q[src_reg[k]];
            end
        end
        war_vec = dst_en ? rs_tbl_q[alloc_rd] : '0;
        waw_vec = dst_en ? rd_tbl_q[alloc_rd] : '0;

        if (DEP_MODE != 0) begin
            dep_vec = (raw_vec | war_vec | waw_vec) & live;
        end else begin
            dep_vec = raw_vec & live;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: combinational next-state logic uses blocking assignments so
        // later statements see earlier updates; the state registers below use
        // non-blocking assignments only.
        valid_d     = valid_q;
        rs_tbl_d    = rs_tbl_q;
        rd_tbl_d    = rd_tbl_q;
        dep_d       = dep_q;
        idt_d       = idt_q;
        idt_valid_d = 1'b0;
        count_d     = count_q;

        // Completion frees the slot and wipes its row and column everywhere,
        // so a later reuse of the slot starts from a clean state.
        if (cmpl_act) begin
            valid_d[cmpl_idx] = 1'b0;
            for (int r = 0; r < REGNUM; r++) begin
                rs_tbl_d[r][cmpl_idx] = 1'b0;
                rd_tbl_d[r][cmpl_idx] = 1'b0;
            end
            for (int i = 0; i < BS; i++) begin
                dep_d[i][cmpl_idx] = 1'b0;
            end
            dep_d[cmpl_idx] = '0;
        end

        // Accept and completion never touch the same slot: the free slot is
        // invalid, while an acting completion targets a valid one.
        if (accept) begin
            valid_d[free_slot] = 1'b1;
            for (int r = 0; r < REGNUM; r++) begin
                rs_tbl_d[r][free_slot] = src_hit[r];
                rd_tbl_d[r][free_slot] = dst_en && (alloc_rd == RW'(r));
            end
            dep_d[free_slot] = dep_vec;
            idt_d            = dep_vec;
            idt_valid_d      = 1'b1;
        end

        case ({accept, cmpl_act})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tables are flop arrays, not RAM, and must be cleared on
            // reset; stale bits would otherwise create false dependencies.
            valid_q <= '0;
            for (int r = 0; r < REGNUM; r++) begin
                rs_tbl_q[r] <= '0;
                rd_tbl_q[r] <= '0;
            end
            for (int i = 0; i < BS; i++) begin
                dep_q[i] <= '0;
            end
            idt_q       <= '0;
            idt_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            rs_tbl_q    <= rs_tbl_d;
            rd_tbl_q    <= rd_tbl_d;
            dep_q       <= dep_d;
            idt_q       <= idt_d;
            idt_valid_q <= idt_valid_d;
            count_q     <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < BS; i++) begin
            ready_vec[i] = valid_q[i] & ~|dep_q[i];
        end
    end

    assign idt       = idt_q;
    assign idt_valid = idt_valid_q;
    assign count     = count_q;

endmodule
